// File: rtl/keycode_decoder.sv
// PS/2 set-2 scancode to key-event decoder: prefix FSM, keycode ROM lookup, event FIFO.
// Optional held-modifier tracking is enabled with `define KEYCODE_DECODER_MODIFIERS_EN.
module keycode_decoder #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scancode_valid_i,
  input  logic [7:0] scancode_i,
  output logic [8:0] rom_addr_o,
  input  logic [7:0] rom_data_i,
  output logic       event_valid_o,
  input  logic       event_ready_i,
  output logic       event_break_o,
  output logic [7:0] event_keycode_o,
  output logic       overflow_o,
  input  logic       overflow_clr_i,
  output logic [2:0] modifiers_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, LOOKUP, WRITE} state_t;

  state_t          state_q, state_d;
  logic [8:0]      rom_addr_q, rom_addr_d;
  logic            brk_q, brk_d;
  logic            ovf_q, ovf_d;
  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic ext_f, brk_f, drop_b, push, pop, full, ovf_set;

  assign full  = (cnt_q == CW'(DEPTH));
  assign pop   = (cnt_q != '0) && event_ready_i;
  assign ext_f = (state_q == EXT) || (state_q == EXT_BRK);
  assign brk_f = (state_q == BRK) || (state_q == EXT_BRK);

  always_comb begin
    drop_b = 1'b0;
    case (scancode_i)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: drop_b = 1'b1;
      default: drop_b = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    brk_d      = brk_q;
    ovf_set    = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE, EXT, BRK, EXT_BRK: begin
        if (scancode_valid_i) begin
          if (scancode_i == 8'hE0)      state_d = brk_f ? EXT_BRK : EXT;
          else if (scancode_i == 8'hF0) state_d = ext_f ? EXT_BRK : BRK;
          else if (drop_b)              state_d = IDLE;
          else begin
            rom_addr_d = {ext_f, scancode_i};
            brk_d      = brk_f;
            state_d    = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        ovf_set = scancode_valid_i;
        state_d = WRITE;
      end
      WRITE: begin
        // A zero ROM word marks an unmapped scancode: swallow it silently.
        if (rom_data_i != 8'h00) begin
          if (full && !pop) ovf_set = 1'b1;
          else              push    = 1'b1;
        end
        if (scancode_valid_i) ovf_set = 1'b1;
        brk_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {brk_q, rom_data_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_set ? 1'b1 : (overflow_clr_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      brk_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      brk_q      <= brk_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign rom_addr_o                       = rom_addr_q;
  assign event_valid_o                    = (cnt_q != '0);
  assign {event_break_o, event_keycode_o} = mem_q[rd_ptr_q];
  assign overflow_o                       = ovf_q;

`ifdef KEYCODE_DECODER_MODIFIERS_EN
  // held bits: {Ralt, Lalt, Rctrl, Lctrl, Rshift, Lshift}
  logic [5:0] held_q, held_d;

  always_comb begin
    held_d = held_q;
    if (state_q == WRITE) begin
      case (rom_addr_q)
        9'h012: held_d[0] = ~brk_q;
        9'h059: held_d[1] = ~brk_q;
        9'h014: held_d[2] = ~brk_q;
        9'h114: held_d[3] = ~brk_q;
        9'h011: held_d[4] = ~brk_q;
        9'h111: held_d[5] = ~brk_q;
        default: held_d = held_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) held_q <= '0;
    else       held_q <= held_d;
  end

  assign modifiers_o = {held_q[5] | held_q[4], held_q[3] | held_q[2], held_q[1] | held_q[0]};
`else
  assign modifiers_o = 3'b000;
`endif

endmodule

// File: tb/tb_keycode_decoder.sv
// Scoreboard bench for keycode_decoder: stimulus pushes expected events, a negedge monitor pops them.
module tb_keycode_decoder;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       scancode_valid_i = 1'b0;
  logic [7:0] scancode_i = '0;
  logic [8:0] rom_addr_o;
  logic [7:0] rom_data_i;
  logic       event_valid_o;
  logic       event_ready_i = 1'b0;
  logic       event_break_o;
  logic [7:0] event_keycode_o;
  logic       overflow_o;
  logic       overflow_clr_i = 1'b0;
  logic [2:0] modifiers_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  keycode_decoder #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .scancode_valid_i(scancode_valid_i), .scancode_i(scancode_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .event_valid_o(event_valid_o), .event_ready_i(event_ready_i),
    .event_break_o(event_break_o), .event_keycode_o(event_keycode_o),
    .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i),
    .modifiers_o(modifiers_o)
  );

  always #5 clk_i = ~clk_i;

  // Keycode ROM image, 1-cycle read latency; unlisted addresses return their low byte.
  function automatic logic [7:0] rom_lookup(input logic [8:0] a);
    case (a)
      9'h01C: return 8'h41;
      9'h175: return 8'h80;
      9'h012: return 8'hE1;
      9'h076: return 8'h00;
      default: return a[7:0];
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i)
    if (rst_i) rom_data_i <= 8'h00;
    else       rom_data_i <= rom_lookup(rom_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && event_valid_o && event_ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", {event_break_o, event_keycode_o});
      end else begin
        chk("event", 32'({event_break_o, event_keycode_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  // One-cycle strobe; returns just after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk_i); #1;
    scancode_valid_i = 1'b1;
    scancode_i = b;
    @(posedge clk_i); #1;
    scancode_valid_i = 1'b0;
  endtask

  // Final byte of a key sequence: wait out LOOKUP and WRITE.
  task automatic key(input logic [7:0] b);
    send(b);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [7:0] makes [5];
  logic [2:0] m_exp;

  initial begin
    makes[0] = 8'h15; makes[1] = 8'h1D; makes[2] = 8'h24; makes[3] = 8'h2D; makes[4] = 8'h2C;
    #12 rst_i = 1'b0;
    idle(1);
    chk("rst_valid", 32'(event_valid_o), 0);
    chk("rst_keycode", 32'(event_keycode_o), 0);
    chk("rst_break", 32'(event_break_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_modifiers", 32'(modifiers_o), 0);
    chk("rst_rom_addr", 32'(rom_addr_o), 0);

    // Single make with latency check
    exp_q.push_back({1'b0, 8'h41});
    send(8'h1C);
    chk("rom_addr_1c", 32'(rom_addr_o), 32'h01C);
    idle(1);
    chk("latency_n2", 32'(event_valid_o), 0);
    idle(1);
    chk("latency_n3", 32'(event_valid_o), 1);
    chk("head_keycode_41", 32'(event_keycode_o), 32'h41);
    chk("head_break_0", 32'(event_break_o), 0);
    event_ready_i = 1'b1;
    idle(1);
    event_ready_i = 1'b0;
    chk("valid_after_pop", 32'(event_valid_o), 0);

    // Extended break
    event_ready_i = 1'b1;
    exp_q.push_back({1'b1, 8'h80});
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("rom_addr_lookup_175", 32'(rom_addr_o), 32'h175);
    idle(4);

    // FIFO overflow with consumer stalled
    event_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({1'b0, makes[i]});
      key(makes[i]);
    end
    chk("full_overflow", 32'(overflow_o), 1);
    chk("full_head", 32'(event_keycode_o), 32'h15);
    overflow_clr_i = 1'b1;
    idle(1);
    overflow_clr_i = 1'b0;
    chk("overflow_cleared", 32'(overflow_o), 0);
    event_ready_i = 1'b1;
    idle(6);
    chk("drained_valid", 32'(event_valid_o), 0);

    // Discarded bytes and unmapped key
    key(8'hFA);
    key(8'hAA);
    key(8'h76);
    idle(2);
    chk("discard_no_event", 32'(event_valid_o), 0);
    chk("discard_no_overflow", 32'(overflow_o), 0);

    // Modifier tracking
    exp_q.push_back({1'b0, 8'hE1});
    key(8'h12);
`ifdef KEYCODE_DECODER_MODIFIERS_EN
    m_exp = 3'b001;
`else
    m_exp = 3'b000;
`endif
    chk("mod_lshift", 32'(modifiers_o), 32'(m_exp));
    exp_q.push_back({1'b0, 8'h14});
    send(8'hE0);
    key(8'h14);
`ifdef KEYCODE_DECODER_MODIFIERS_EN
    m_exp = 3'b011;
`endif
    chk("mod_rctrl", 32'(modifiers_o), 32'(m_exp));
    exp_q.push_back({1'b1, 8'hE1});
    send(8'hF0);
    key(8'h12);
`ifdef KEYCODE_DECODER_MODIFIERS_EN
    m_exp = 3'b010;
`endif
    chk("mod_lshift_break", 32'(modifiers_o), 32'(m_exp));
    idle(3);

    // Reset after E0 loses the extended flag
    send(8'hE0);
    #2 rst_i = 1'b1;
    #3 rst_i = 1'b0;
    chk("reset_mid_valid", 32'(event_valid_o), 0);
    exp_q.push_back({1'b0, 8'h75});
    send(8'h75);
    chk("rom_addr_after_rst", 32'(rom_addr_o), 32'h075);
    idle(4);

    // Byte during LOOKUP is dropped and flagged
    exp_q.push_back({1'b0, 8'h41});
    send(8'h1C);
    scancode_valid_i = 1'b1;
    scancode_i = 8'h15;
    idle(1);
    scancode_valid_i = 1'b0;
    idle(2);
    chk("lookup_drop_overflow", 32'(overflow_o), 1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("final_valid", 32'(event_valid_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
